// File: rtl/openmips_rst_ctrl.sv
// ---------------------------------------------------------------------------
// openmips_rst_ctrl
// Reset/run controller between the board reset pin and the openmips_min_sopc
// core. The active-low board reset is asserted asynchronously and released
// through a synchronizer. The release is stretched by a hold period before
// the core's active-high reset (cpu_rst) drops. The core reset is re-applied
// on a one-cycle software request. Run cycles are counted in a saturating
// counter.
//
// Optional feature, enabled by `define RST_CTRL_CYCLE_LIMIT_EN:
//   After CYCLE_LIMIT run cycles the core is parked in HALT with cpu_rst=1
//   and halt=1. It leaves HALT only through rst or sw_rst_req. When the
//   macro is undefined, the HALT state and the limit comparator are not built
//   and halt is tied low.
// ---------------------------------------------------------------------------
module openmips_rst_ctrl #(
    parameter int SYNC_STAGES = 2,   // release synchronizer depth, >= 2
    parameter int HOLD_CYCLES = 10,  // extra reset cycles after sync release
    parameter int CNT_W       = 16,  // width of cycle_cnt and hold counter
    parameter int CYCLE_LIMIT = 200  // run cycles before HALT (limit build only)
) (
    input  logic             clk,
    input  logic             rst,         // async, active-low board reset
    input  logic             sw_rst_req,  // 1-cycle software reset request
    output logic             cpu_rst,     // core reset, active-high
    output logic             rst_done,    // pulse on the first RUN cycle
    output logic             halt,        // high while parked in HALT
    output logic [CNT_W-1:0] cycle_cnt    // saturating RUN cycle count
);

    // Hold counter value on the last HOLD cycle. It is unused when the hold
    // period is zero, because ASSERT then goes straight to RUN.
    localparam logic [CNT_W-1:0] HOLD_LAST =
        (HOLD_CYCLES > 0) ? CNT_W'(HOLD_CYCLES - 1) : '0;
    localparam bit               SKIP_HOLD = (HOLD_CYCLES == 0);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

`ifdef RST_CTRL_CYCLE_LIMIT_EN
    // RUN leaves for HALT on the edge where the count would reach the limit.
    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(CYCLE_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(CYCLE_LIMIT - 1);
`endif

    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_HOLD   = 2'd1,
        ST_RUN    = 2'd2
`ifdef RST_CTRL_CYCLE_LIMIT_EN
        ,
        ST_HALT   = 2'd3
`endif
    } state_t;

    // Saturating increment. The run counter sticks at all-ones and never wraps.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_out_s;
    state_t                 state_r;
    logic [CNT_W-1:0]       hold_cnt_r;
    logic [CNT_W-1:0]       cycle_cnt_r;
    logic                   cpu_rst_r;
    logic                   rst_done_r;

    // Release synchronizer. It clears immediately on rst and shifts in ones
    // after rst rises, so deassertion is always aligned to clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_out_s = sync_r[SYNC_STAGES-1];

`ifdef RST_CTRL_CYCLE_LIMIT_EN
    logic halt_r;
`endif

    // Sequencing FSM. All outputs are registered here. The software request
    // outranks the cycle limit and is ignored while already in ASSERT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_ASSERT;
            hold_cnt_r  <= '0;
            cycle_cnt_r <= '0;
            cpu_rst_r   <= 1'b1;
            rst_done_r  <= 1'b0;
`ifdef RST_CTRL_CYCLE_LIMIT_EN
            halt_r      <= 1'b0;
`endif
        end else if (sw_rst_req && (state_r != ST_ASSERT)) begin
            // The synchronizer is left full, so HOLD follows after one cycle.
            state_r     <= ST_ASSERT;
            hold_cnt_r  <= '0;
            cycle_cnt_r <= '0;
            cpu_rst_r   <= 1'b1;
            rst_done_r  <= 1'b0;
`ifdef RST_CTRL_CYCLE_LIMIT_EN
            halt_r      <= 1'b0;
`endif
        end else begin
            rst_done_r <= 1'b0;
            case (state_r)
                ST_ASSERT: begin
                    cpu_rst_r <= 1'b1;
                    if (sync_out_s && (hold_cnt_r == '0)) begin
                        if (SKIP_HOLD) begin
                            state_r    <= ST_RUN;
                            cpu_rst_r  <= 1'b0;
                            rst_done_r <= 1'b1;
                        end else begin
                            state_r    <= ST_HOLD;
                        end
                    end else begin
                        state_r <= ST_ASSERT;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt_r == HOLD_LAST) begin
                        state_r    <= ST_RUN;
                        hold_cnt_r <= '0;
                        cpu_rst_r  <= 1'b0;
                        rst_done_r <= 1'b1;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + CNT_W'(1);
                        cpu_rst_r  <= 1'b1;
                    end
                end
                ST_RUN: begin
`ifdef RST_CTRL_CYCLE_LIMIT_EN
                    if (cycle_cnt_r == LIMIT_M1) begin
                        state_r     <= ST_HALT;
                        cycle_cnt_r <= LIMIT;
                        cpu_rst_r   <= 1'b1;
                        halt_r      <= 1'b1;
                    end else begin
                        cycle_cnt_r <= sat_inc(cycle_cnt_r);
                        cpu_rst_r   <= 1'b0;
                    end
`else
                    cycle_cnt_r <= sat_inc(cycle_cnt_r);
                    cpu_rst_r   <= 1'b0;
`endif
                end
`ifdef RST_CTRL_CYCLE_LIMIT_EN
                ST_HALT: begin
                    // The count stays frozen at the limit until a reset.
                    cpu_rst_r <= 1'b1;
                    halt_r    <= 1'b1;
                end
`endif
                default: begin
                    state_r     <= ST_ASSERT;
                    hold_cnt_r  <= '0;
                    cycle_cnt_r <= '0;
                    cpu_rst_r   <= 1'b1;
                end
            endcase
        end
    end

    assign cpu_rst   = cpu_rst_r;
    assign rst_done  = rst_done_r;
    assign cycle_cnt = cycle_cnt_r;
`ifdef RST_CTRL_CYCLE_LIMIT_EN
    assign halt      = halt_r;
`else
    assign halt      = 1'b0;
`endif

endmodule

// File: tb/tb_openmips_rst_ctrl.sv
// ---------------------------------------------------------------------------
// tb_openmips_rst_ctrl
// Three instances share the clock, the board reset and the software request:
//   a: default parameters
//   b: CNT_W=4, CYCLE_LIMIT=10 (saturation)
//   c: HOLD_CYCLES=0
// The reference model describes each instance as a countdown of edges left
// before the core runs, plus a run count and a halted flag. Outputs are
// compared on every falling clock edge. The bench also runs directed checks
// for latency, asynchronous assertion, the software request and the limit.
// Build with RST_CTRL_CYCLE_LIMIT_EN defined to exercise the limit feature.
// ---------------------------------------------------------------------------
module tb_openmips_rst_ctrl;

`ifdef RST_CTRL_CYCLE_LIMIT_EN
    localparam bit LIM_EN = 1'b1;
`else
    localparam bit LIM_EN = 1'b0;
`endif
    localparam int SYNC = 2;

    logic clk;
    logic rst;
    logic sw_rst_req;

    logic        cpu_rst_a, rst_done_a, halt_a;
    logic [15:0] cnt_a;
    logic        cpu_rst_b, rst_done_b, halt_b;
    logic [3:0]  cnt_b;
    logic        cpu_rst_c, rst_done_c, halt_c;
    logic [15:0] cnt_c;

    int n_tests = 0;
    int n_fail  = 0;

    openmips_rst_ctrl dut_a (
        .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req),
        .cpu_rst(cpu_rst_a), .rst_done(rst_done_a), .halt(halt_a), .cycle_cnt(cnt_a)
    );

    openmips_rst_ctrl #(.CNT_W(4), .CYCLE_LIMIT(10)) dut_b (
        .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req),
        .cpu_rst(cpu_rst_b), .rst_done(rst_done_b), .halt(halt_b), .cycle_cnt(cnt_b)
    );

    openmips_rst_ctrl #(.HOLD_CYCLES(0)) dut_c (
        .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req),
        .cpu_rst(cpu_rst_c), .rst_done(rst_done_c), .halt(halt_c), .cycle_cnt(cnt_c)
    );

    // 20 ns clock
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // ---------------- reference model ----------------
    int hold_p[3] = '{10, 10, 0};
    int lim_p[3]  = '{200, 10, 200};
    int max_p[3]  = '{65535, 15, 65535};
    int wl[3];     // edges still to go before the core runs
    int mcnt[3];   // run cycles counted
    bit mhalt[3];
    bit mdone[3];

    // Model: board reset reloads the full release delay. An accepted software
    // request (any time past the ASSERT window) reloads one ASSERT cycle plus
    // the hold period. Once running, the model counts edges up to the limit
    // or to saturation.
    always @(posedge clk or negedge rst) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst) begin
                wl[i]    <= SYNC + hold_p[i] + 1;
                mcnt[i]  <= 0;
                mhalt[i] <= 1'b0;
                mdone[i] <= 1'b0;
            end else if (sw_rst_req && (wl[i] <= hold_p[i])) begin
                wl[i]    <= hold_p[i] + 1;
                mcnt[i]  <= 0;
                mhalt[i] <= 1'b0;
                mdone[i] <= 1'b0;
            end else if (wl[i] > 0) begin
                wl[i]    <= wl[i] - 1;
                mdone[i] <= (wl[i] == 1);
            end else begin
                mdone[i] <= 1'b0;
                if (!mhalt[i]) begin
                    if (LIM_EN && (mcnt[i] + 1 == lim_p[i])) begin
                        mcnt[i]  <= lim_p[i];
                        mhalt[i] <= 1'b1;
                    end else if (mcnt[i] < max_p[i]) begin
                        mcnt[i] <= mcnt[i] + 1;
                    end
                end
            end
        end
    end

    function automatic logic exp_cpu_rst(input int i);
        return (wl[i] != 0) || mhalt[i];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("a_cpu_rst",  {31'd0, cpu_rst_a},  {31'd0, exp_cpu_rst(0)});
        check("a_rst_done", {31'd0, rst_done_a}, {31'd0, mdone[0]});
        check("a_halt",     {31'd0, halt_a},     {31'd0, mhalt[0]});
        check("a_cnt",      {16'd0, cnt_a},      mcnt[0]);
        check("b_cpu_rst",  {31'd0, cpu_rst_b},  {31'd0, exp_cpu_rst(1)});
        check("b_rst_done", {31'd0, rst_done_b}, {31'd0, mdone[1]});
        check("b_halt",     {31'd0, halt_b},     {31'd0, mhalt[1]});
        check("b_cnt",      {28'd0, cnt_b},      mcnt[1]);
        check("c_cpu_rst",  {31'd0, cpu_rst_c},  {31'd0, exp_cpu_rst(2)});
        check("c_rst_done", {31'd0, rst_done_c}, {31'd0, mdone[2]});
        check("c_halt",     {31'd0, halt_c},     {31'd0, mhalt[2]});
        check("c_cnt",      {16'd0, cnt_c},      mcnt[2]);
    end

    // ---------------- directed helpers ----------------
    // Release rst now and count posedges until each core leaves reset.
    task automatic release_and_measure(input string tag);
        int n_a;
        int n_c;
        n_a = 0;
        n_c = 0;
        rst = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (n_a == 0 && cpu_rst_a == 1'b0) begin
                n_a = n;
                check({tag, "_done_pulse"}, {31'd0, rst_done_a}, 32'd1);
            end
            if (n_c == 0 && cpu_rst_c == 1'b0) n_c = n;
        end
        check({tag, "_latency"},    n_a, 32'd13);
        check({tag, "_latency_h0"}, n_c, 32'd3);
    endtask

    // Wait (bounded) for a given count on instance a; returns on a falling edge.
    task automatic wait_cnt_a(input int target, input int budget, input string tag);
        int k;
        k = 0;
        while (cnt_a !== 16'(target) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_reached"}, {31'd0, (cnt_a === 16'(target))}, 32'd1);
    endtask

    task automatic board_reset(input int cycles);
        rst = 1'b0;
        repeat (cycles) @(negedge clk);
        #2;
        rst = 1'b1;
    endtask

    // Watchdog
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n_a;
        int n_c;
        int r;
        rst        = 1'b0;
        sw_rst_req = 1'b0;

        // Reset state, after the first clock edge has settled the registers.
        #15;
        check("reset_cpu_rst",  {31'd0, cpu_rst_a},  32'd1);
        check("reset_rst_done", {31'd0, rst_done_a}, 32'd0);
        check("reset_halt",     {31'd0, halt_a},     32'd0);
        check("reset_cnt",      {16'd0, cnt_a},      32'd0);

        // Power-on release at 195 ns.
        #180;
        release_and_measure("poweron");

        // Software reset at cycle_cnt == 50.
        wait_cnt_a(50, 200, "sw50");
        #2;
        sw_rst_req = 1'b1;
        n_a = 0;
        n_c = 0;
        for (int n = 1; n <= 16; n++) begin
            @(posedge clk);
            #1;
            sw_rst_req = 1'b0;
            if (n == 1) begin
                check("sw_cpu_rst_next", {31'd0, cpu_rst_a}, 32'd1);
                check("sw_cnt_clear",    {16'd0, cnt_a},     32'd0);
            end
            if (n_a == 0 && cpu_rst_a == 1'b0) begin
                n_a = n;
                check("sw_done_pulse", {31'd0, rst_done_a}, 32'd1);
            end
            if (n_c == 0 && cpu_rst_c == 1'b0) n_c = n;
        end
        check("sw_latency",    n_a, 32'd12);
        check("sw_latency_h0", n_c, 32'd2);

        // Asynchronous assertion in the middle of RUN, with no clock edge.
        wait_cnt_a(20, 100, "async20");
        #5;
        rst = 1'b0;
        #1;
        check("async_cpu_rst",  {31'd0, cpu_rst_a},  32'd1);
        check("async_cnt",      {16'd0, cnt_a},      32'd0);
        check("async_rst_done", {31'd0, rst_done_a}, 32'd0);
        @(negedge clk);
        #2;
        release_and_measure("async");

        // Randomized phase: software requests, sub-cycle glitches, long resets.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            #2;
            r = int'($urandom_range(0, 199));
            if (r < 6) begin
                sw_rst_req = 1'b1;
                @(negedge clk);
                #2;
                sw_rst_req = 1'b0;
            end else if (r == 6) begin
                #($urandom_range(0, 3));
                rst = 1'b0;
                #1;
                check("glitch_cpu_rst", {31'd0, cpu_rst_a}, 32'd1);
                check("glitch_cnt",     {16'd0, cnt_a},     32'd0);
                #($urandom_range(1, 2));
                rst = 1'b1;
            end else if (r == 7) begin
                board_reset(int'($urandom_range(1, 4)));
            end
        end

        // Quiet run from a fresh reset: the limit or unbounded RUN, and saturation.
        @(negedge clk);
        #2;
        board_reset(2);
        repeat (450) @(negedge clk);
        check("limit_halt",     {31'd0, halt_a},             {31'd0, LIM_EN});
        check("limit_cpu_rst",  {31'd0, cpu_rst_a},          {31'd0, LIM_EN});
        check("limit_cnt_ge",   {31'd0, (cnt_a >= 16'd200)}, 32'd1);
        check("sat_stick",      {28'd0, cnt_b},              LIM_EN ? 32'd10 : 32'd15);

        // A software request leaves HALT.
        #2;
        sw_rst_req = 1'b1;
        @(negedge clk);
        #2;
        sw_rst_req = 1'b0;
        check("sw_exit_halt", {31'd0, halt_a}, 32'd0);
        repeat (20) @(negedge clk);

        // Collision: the request lands on the edge where the limit would hit.
        #2;
        board_reset(1);
        wait_cnt_a(199, 400, "coll199");
        #2;
        sw_rst_req = 1'b1;
        @(posedge clk);
        #1;
        sw_rst_req = 1'b0;
        check("coll_halt",    {31'd0, halt_a},    32'd0);
        check("coll_cpu_rst", {31'd0, cpu_rst_a}, 32'd1);
        check("coll_cnt",     {16'd0, cnt_a},     32'd0);
        repeat (30) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
